// File: rtl/cp0_exception_controller_if.sv
// Signal bundle between write-back, CP0 and fetch, as seen by the exception controller.
// master = controller side, slave = pipeline/CP0/fetch side.
interface cp0_exception_controller_if;
  // write-back instruction
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_exception;
  logic [4:0]  wb_exception_code;
  logic [31:0] wb_pc;
  logic        wb_in_delay_slot;
  logic [31:0] wb_bad_vaddr;
  logic        wb_eret;
  // current CP0 state
  logic        status_ie;
  logic        status_exl;
  logic [7:0]  status_im;
  logic [7:0]  cause_ip;
  logic [31:0] epc;
  // CP0 update strobes
  logic        cp0_exception_valid;
  logic [4:0]  cp0_exception_code;
  logic [31:0] cp0_epc;
  logic        cp0_in_delay_slot;
  logic        cp0_bad_vaddr_we;
  logic [31:0] cp0_bad_vaddr;
  logic        cp0_eret;
  // pipeline control / fetch redirect
  logic        flush;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;

  modport master (
    input  wb_valid, wb_exception, wb_exception_code, wb_pc, wb_in_delay_slot,
           wb_bad_vaddr, wb_eret, status_ie, status_exl, status_im, cause_ip, epc,
           redirect_ready,
    output wb_ready, cp0_exception_valid, cp0_exception_code, cp0_epc,
           cp0_in_delay_slot, cp0_bad_vaddr_we, cp0_bad_vaddr, cp0_eret, flush,
           redirect_valid, redirect_pc
  );

  modport slave (
    output wb_valid, wb_exception, wb_exception_code, wb_pc, wb_in_delay_slot,
           wb_bad_vaddr, wb_eret, status_ie, status_exl, status_im, cause_ip, epc,
           redirect_ready,
    input  wb_ready, cp0_exception_valid, cp0_exception_code, cp0_epc,
           cp0_in_delay_slot, cp0_bad_vaddr_we, cp0_bad_vaddr, cp0_eret, flush,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/cp0_exception_controller.sv
// CP0 exception sequencer: commits exceptions/interrupts/eret at write-back,
// strobes CP0 in the commit cycle, flushes for DRAIN_CYCLES, then redirects fetch.
module cp0_exception_controller #(
  parameter logic [31:0] EXCEPTION_VECTOR = 32'hbfc0_0380,
  parameter int          DRAIN_CYCLES     = 2
) (
  input logic                        clock,
  input logic                        reset,
  cp0_exception_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);
  localparam logic [4:0] EXC_INT    = 5'h00;
  localparam logic [4:0] EXC_ADEL   = 5'h04;
  localparam logic [4:0] EXC_ADES   = 5'h05;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] rpc, rpc_nxt;

  logic int_req, commit, take_int, take_exc;

  // Event decode; interrupt outranks an instruction exception, which outranks eret.
  always_comb begin
    int_req  = bus.status_ie & ~bus.status_exl & (|(bus.cause_ip & bus.status_im));
    commit   = ~reset & (state == IDLE) & bus.wb_valid &
               (int_req | bus.wb_exception | bus.wb_eret);
    take_int = int_req;
    take_exc = ~int_req & bus.wb_exception;
  end

  // State, drain counter and latched redirect target; reset aborts any sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rpc   <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rpc   <= rpc_nxt;
    end
  end

  // Next state and outputs; CP0 strobes are only ever driven in the commit cycle.
  always_comb begin
    state_nxt               = state;
    cnt_nxt                 = cnt;
    rpc_nxt                 = rpc;
    bus.wb_ready            = (state == IDLE);
    bus.cp0_exception_valid = 1'b0;
    bus.cp0_exception_code  = 5'd0;
    bus.cp0_epc             = 32'd0;
    bus.cp0_in_delay_slot   = 1'b0;
    bus.cp0_bad_vaddr_we    = 1'b0;
    bus.cp0_bad_vaddr       = 32'd0;
    bus.cp0_eret            = 1'b0;
    bus.flush               = 1'b0;
    bus.redirect_valid      = 1'b0;
    bus.redirect_pc         = rpc;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (commit) begin
            bus.flush = 1'b1;
            state_nxt = DRAIN;
            cnt_nxt   = DRAIN_LOAD;
            if (take_int || take_exc) begin
              bus.cp0_exception_valid = 1'b1;
              bus.cp0_exception_code  = take_int ? EXC_INT : bus.wb_exception_code;
              bus.cp0_epc             = bus.wb_in_delay_slot ? bus.wb_pc - 32'd4 : bus.wb_pc;
              bus.cp0_in_delay_slot   = bus.wb_in_delay_slot;
              bus.cp0_bad_vaddr_we    = take_exc &&
                                        (bus.wb_exception_code == EXC_ADEL ||
                                         bus.wb_exception_code == EXC_ADES);
              bus.cp0_bad_vaddr       = bus.wb_bad_vaddr;
              rpc_nxt                 = EXCEPTION_VECTOR;
            end else begin
              bus.cp0_eret = 1'b1;
              rpc_nxt      = bus.epc;
            end
          end
        end
        DRAIN: begin
          bus.flush = 1'b1;
          cnt_nxt   = cnt - 4'd1;
          // <= 1 rather than == 1 so an out-of-range load of 0 cannot spin 16 cycles
          if (cnt <= 4'd1) state_nxt = REDIRECT;
        end
        REDIRECT: begin
          bus.redirect_valid = 1'b1;
          if (bus.redirect_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: doc/cp0_exception_controller.md
# cp0_exception_controller

Sequencer between the write-back stage and coprocessor 0. It detects instruction exceptions, enabled interrupts and `eret` as the write-back instruction commits, and drives the CP0 update strobes (EPC, Cause.ExcCode/BD, BadVAddr, Status.EXL). It then flushes the pipeline for a fixed drain window and hands a redirect PC to fetch through a valid/ready handshake. It is the only writer of the CP0 exception-entry and `eret` fields.

## Interface

Parameters:
- `EXCEPTION_VECTOR`, default 32'hbfc0_0380: redirect target for every exception and interrupt.
- `DRAIN_CYCLES`, default 2: flush cycles after the commit cycle; legal range 1..15.

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `wb_valid` in 1: write-back holds a valid instruction this cycle.
- `wb_ready` out 1: controller accepts the write-back instruction; high only in IDLE.
- `wb_exception` in 1: the instruction carries an exception.
- `wb_exception_code` in 5: MIPS ExcCode for that exception.
- `wb_pc` in 32: PC of the instruction.
- `wb_in_delay_slot` in 1: the instruction is in a branch delay slot.
- `wb_bad_vaddr` in 32: faulting address.
- `wb_eret` in 1: the instruction is `eret`.
- `status_ie`, `status_exl` in 1 each: current Status.IE and Status.EXL.
- `status_im` in 8: Status.IM.
- `cause_ip` in 8: Cause.IP pending bits.
- `epc` in 32: current EPC value.
- `cp0_exception_valid` out 1: exception-entry write strobe (EPC, BD, ExcCode, EXL←1).
- `cp0_exception_code` out 5: ExcCode to write.
- `cp0_epc` out 32: EPC to write.
- `cp0_in_delay_slot` out 1: BD to write.
- `cp0_bad_vaddr_we` out 1: BadVAddr write enable.
- `cp0_bad_vaddr` out 32: BadVAddr value.
- `cp0_eret` out 1: `eret` strobe (EXL←0).
- `flush` out 1: flush all pipeline stages younger than write-back.
- `redirect_valid` out 1: the redirect PC is valid.
- `redirect_ready` in 1: fetch accepts the redirect.
- `redirect_pc` out 32: new fetch PC.

## Operation

Interrupt request:
- `int_req = status_ie & ~status_exl & |(cause_ip & status_im)`.

Commit event:
- A commit event occurs in IDLE when `wb_valid` is high and any of these holds: `int_req`, `wb_exception`, `wb_eret`.
- Priority is interrupt > `wb_exception` > `wb_eret`. Only the winning event acts.

Exception entry (interrupt or exception):
- `cp0_exception_valid` = 1.
- Code is 5'h00 for an interrupt, otherwise `wb_exception_code`.
- `cp0_epc` = `wb_in_delay_slot` ? `wb_pc - 4` : `wb_pc`, with 32-bit wrap.
- `cp0_in_delay_slot` = `wb_in_delay_slot`.
- `cp0_bad_vaddr_we` = 1 only for a non-interrupt with code 5'h04 (AdEL) or 5'h05 (AdES). `cp0_bad_vaddr` = `wb_bad_vaddr`.
- The redirect target is `EXCEPTION_VECTOR`.

`eret`:
- `cp0_eret` = 1.
- The redirect target is the `epc` value sampled in the commit cycle.

FSM states:
- IDLE → DRAIN on a commit event. The redirect target is latched into `redirect_pc` and the drain counter is loaded with `DRAIN_CYCLES`.
- DRAIN → REDIRECT when the counter reaches 1. The counter decrements each DRAIN cycle. Counter width is 4 bits.
- REDIRECT → IDLE on `redirect_valid & redirect_ready`.

Per-state outputs:
- In the commit cycle (IDLE with a commit event), `flush` and the `cp0_*` strobes are combinational from the write-back inputs, so CP0 samples them on the same edge.
- In DRAIN, `flush` is 1 and all `cp0_*` strobes are 0.
- In REDIRECT, `redirect_valid` is 1 and `flush` is 0. `redirect_pc` holds stable until the handshake completes.
- `wb_ready` is 1 only in IDLE. Write-back holds its instruction while `wb_ready` is 0. No commit event is evaluated outside IDLE.

## Timing

Reset:
- State is IDLE. `redirect_pc` = 0, the counter is 0, `redirect_valid` = 0, `flush` = 0, all `cp0_*` outputs = 0, `wb_ready` = 1 (the first cycle after reset is release).
- Reset mid-DRAIN or mid-REDIRECT aborts to IDLE on the next edge, with no further strobes.

Sequence latency:
- Commit cycle T: strobes and `flush`.
- T+1..T+DRAIN_CYCLES: `flush` only.
- T+DRAIN_CYCLES+1: `redirect_valid` rises.
- The first new commit event can be evaluated the cycle after the handshake.

Boundary cases:
- With `redirect_ready` tied high, the sequence is exactly DRAIN_CYCLES+2 cycles long.
- `int_req` changing during DRAIN or REDIRECT has no effect.
- A pending interrupt with `wb_valid` = 0 is not taken. It is attached to the next valid instruction.
- Strobes are single-cycle pulses. They are never asserted while `wb_ready` = 0.

## Test plan

- Reset, then `wb_valid` = 1 with no event → `wb_ready` = 1, all strobes 0, state remains IDLE.
- Exception at pc 0x8000_1000, code 0x04, bad_vaddr 0x0000_0003, not in delay slot (DRAIN_CYCLES = 2) → T: `cp0_exception_valid` = 1, epc 0x8000_1000, `cp0_bad_vaddr_we` = 1; `flush` high at T, T+1, T+2; `redirect_valid` at T+3 with pc 0xbfc0_0380.
- Delay-slot exception at pc 0x8000_2004, code 0x0a → epc 0x8000_2000, BD = 1, `cp0_bad_vaddr_we` = 0.
- `eret` with `epc` = 0x8000_3000 and `redirect_ready` held low for 4 cycles → `cp0_eret` pulses once; `redirect_pc` stays 0x8000_3000 until the handshake; `wb_ready` = 0 throughout.
- `status_ie` = 1, `status_exl` = 0, `im` = 0x01, `ip` = 0x01, together with `wb_exception` code 0x0c and `wb_eret` → code 0x00 (interrupt wins), single strobe. Repeating with `status_exl` = 1 → code 0x0c is taken instead.
- `reset` asserted during DRAIN → IDLE and all outputs 0 the next cycle; no `redirect_valid` ever appears.
